lsu_mem_arbiter: RTL and testbench
==================================

# lsu_mem_arbiter

Load/store controller and two-port arbiter in front of the single-ported data memory. It accepts byte-addressed RV32 load/store requests from the core LSU and from the debug/boot-loader port, and grants one per access slot. It generates word address, byte-lane write enables and lane-replicated write data, then returns aligned, sign/zero-extended load data with a fault flag. The block sits between the execute/memory stage plus debug bridge and the byte-writable, combinational-read data RAM.

## Interface
- ADDR_WIDTH, 10: memory word-address width; the valid byte range is 0 to 2^(ADDR_WIDTH+2)-1.
- DATA_WIDTH, 32: fixed at 32; any other value is illegal.

Ports (`x` = `core` and `dbg`; each port set is identical):
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- x_req_valid  in  1  request present.
- x_req_ready  out  1  request accepted this cycle.
- x_req_addr  in  32  byte address.
- x_req_write  in  1  1 = store, 0 = load.
- x_req_funct3  in  3  RV32 funct3 (LB/LH/LW/LBU/LHU; SB/SH/SW).
- x_req_wdata  in  32  store data, right-justified.
- x_rsp_valid  out  1  response present.
- x_rsp_ready  in  1  response consumed.
- x_rsp_rdata  out  32  extended load data; 0 for stores and faults.
- x_rsp_fault  out  1  misaligned, out-of-range or illegal funct3.
- mem_addr  out  ADDR_WIDTH  word address, = req_addr[ADDR_WIDTH+1:2].
- mem_we  out  4  byte-lane write enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_rdata  in  32  combinational read data.

## Operation
- FSM states:
  - INIT: entered on reset; lasts exactly 1 cycle after rst_n rises.
  - IDLE: arbitrates and issues the granted access.
  - RESP: holds the response.
- Arbitration in IDLE:
  - Exactly one valid requester: it is granted.
  - Both valid: grant the one not granted last (round-robin). The `last` register resets to `dbg`, so `core` wins the first tie.
- Grant cycle: the granted x_req_ready = 1 and the access is issued. The other port's ready = 0. Then move to RESP.
- Store lane enables, with off = addr[1:0]:
  - SB: mem_we = 1<<off; mem_wdata = {4{wdata[7:0]}}.
  - SH: mem_we = 4'b0011 when off = 0, 4'b1100 when off = 2; mem_wdata = {2{wdata[15:0]}}.
  - SW: mem_we = 4'b1111; mem_wdata = wdata.
- Loads:
  - mem_rdata is sampled in the grant cycle.
  - The lane is selected by off.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - The result is registered into rsp_rdata.
- Fault cases:
  - Halfword with addr[0] = 1.
  - Word with off != 0.
  - addr[31:ADDR_WIDTH+2] != 0.
  - Illegal funct3: 3, 6 or 7 for loads; anything > 2 for stores.
- On fault: mem_we = 0 (memory untouched), rsp_fault = 1, rsp_rdata = 0. The request is still accepted.
- RESP: the granted port sees rsp_valid = 1; rdata and fault are held stable until rsp_ready = 1, then the FSM returns to IDLE. No grant is made while in RESP.
- Outside the grant cycle, mem_we = 0. mem_addr and mem_wdata are don't-care when mem_we = 0 and the FSM is not in the grant cycle.

## Timing
- Reset values: state = INIT; all req_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_fault = 0, mem_we = 0.
- Reset asserted mid-access (any state): all outputs above go to their reset values immediately (asynchronously). Any pending response is dropped.
- No request can be accepted before the second rising edge after rst_n is released.
- Cycle T is the grant cycle: the write commits at the clk edge ending T, and rsp_valid is first high in T+1.
- Minimum per access is 2 cycles (T and T+1 with rsp_ready = 1). The next grant is possible at T+2.
- Requesters must hold valid and payload stable until ready. Behaviour on a payload change while valid is unspecified.
- Combinational paths:
  - x_req_valid -> x_req_ready and mem_* (same cycle).
  - mem_rdata -> registered response only; no mem_rdata -> rsp path.

## Structure
- Shared package `lsu_pkg` contains:
  - funct3 constants: F3_B = 0, F3_H = 1, F3_W = 2, F3_BU = 4, F3_HU = 5.
  - FSM enum: INIT, IDLE, RESP.
  - Requester-id enum: REQ_CORE, REQ_DBG.
- Sub-module `lsu_align` (purely combinational):
  - Inputs: funct3, write, offset, wdata, rdata.
  - Outputs: we, replicated wdata, extended load data, misalign flag.
- Arbiter, FSM and response registers live in the top module.

## Test plan
- Lane extraction:
  - Preload word 0 = 0xDEADBEEF.
  - core LB addr 0x3 -> rsp_rdata = 0xFFFFFFDE, fault = 0.
  - LBU 0x3 -> 0x000000DE.
  - LH 0x2 -> 0xFFFFDEAD.
  - LHU 0x0 -> 0x0000BEEF.
- Store lanes:
  - Preload word 1 = 0x00000005.
  - core SH addr 0x6, wdata 0x1234ABCD -> mem_we = 4'b1100, mem_addr = 1, mem_wdata = 0xABCDABCD.
  - Then LW 0x4 -> 0xABCD0005.
- Arbitration:
  - Both ports valid continuously from reset -> grant order core, dbg, core, dbg.
  - Each grant is followed by exactly one rsp_valid on the same port.
- Faults:
  - SW addr 0x2 -> fault = 1, mem_we = 0, memory unchanged.
  - LW addr 0x1000 (ADDR_WIDTH = 10) -> fault = 1, rdata = 0.
  - Load funct3 = 3 -> fault = 1.
- Backpressure: hold core_rsp_ready low for 5 cycles -> rsp_valid/rdata stable, dbg_req_ready stays 0, no mem_we.
- Reset mid-operation:
  - Drop rst_n while in RESP -> rsp_valid = 0 immediately.
  - After release: one cycle with ready = 0, then a pending request is granted.

Source files
------------

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared funct3 codes, FSM and requester enums for the LSU memory arbiter
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        IDLE = 2'd1,
        RESP = 2'd2
    } lsu_state_e;

    typedef enum logic {
        REQ_CORE = 1'b0,
        REQ_DBG  = 1'b1
    } req_id_e;

    // Stores have no unsigned variants, so only B/H/W are legal for them.
    function automatic logic f3_legal(input logic [2:0] funct3, input logic write);
        if (write) begin
            return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        end
        return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
               (funct3 == F3_BU) || (funct3 == F3_HU);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane enables, store replication and load extension for one access
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic        i_write,
    input  logic [1:0]  i_offset,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_we,
    output logic [31:0] o_wdata,
    output logic [31:0] o_ldata,
    output logic        o_misalign
);

    logic [31:0] w_shifted;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_shifted = i_rdata >> {i_offset, 3'b000};
    assign w_byte    = w_shifted[7:0];
    assign w_half    = i_offset[1] ? i_rdata[31:16] : i_rdata[15:0];

    // funct3[2] marks the unsigned load variants.
    always_comb begin
        o_we       = 4'b0000;
        o_wdata    = i_wdata;
        o_ldata    = 32'h0;
        o_misalign = 1'b0;
        case (i_funct3[1:0])
            2'd0: begin
                o_we    = 4'b0001 << i_offset;
                o_wdata = {4{i_wdata[7:0]}};
                o_ldata = i_funct3[2] ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
            end
            2'd1: begin
                o_misalign = i_offset[0];
                o_we       = i_offset[1] ? 4'b1100 : 4'b0011;
                o_wdata    = {2{i_wdata[15:0]}};
                o_ldata    = i_funct3[2] ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
            end
            2'd2: begin
                o_misalign = (i_offset != 2'd0);
                o_we       = 4'b1111;
                o_ldata    = i_rdata;
            end
            default: begin
                o_we = 4'b0000;
            end
        endcase
        if (!i_write) begin
            o_we = 4'b0000;
        end
    end

endmodule

// File: rtl/lsu_mem_arbiter.sv
// rtl/lsu_mem_arbiter.sv - round-robin core/debug arbiter and load/store controller for the data RAM
module lsu_mem_arbiter
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  core_req_valid,
    output logic                  core_req_ready,
    input  logic [31:0]           core_req_addr,
    input  logic                  core_req_write,
    input  logic [2:0]            core_req_funct3,
    input  logic [DATA_WIDTH-1:0] core_req_wdata,
    output logic                  core_rsp_valid,
    input  logic                  core_rsp_ready,
    output logic [DATA_WIDTH-1:0] core_rsp_rdata,
    output logic                  core_rsp_fault,
    input  logic                  dbg_req_valid,
    output logic                  dbg_req_ready,
    input  logic [31:0]           dbg_req_addr,
    input  logic                  dbg_req_write,
    input  logic [2:0]            dbg_req_funct3,
    input  logic [DATA_WIDTH-1:0] dbg_req_wdata,
    output logic                  dbg_rsp_valid,
    input  logic                  dbg_rsp_ready,
    output logic [DATA_WIDTH-1:0] dbg_rsp_rdata,
    output logic                  dbg_rsp_fault,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_we,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    lsu_state_e            r_state;
    req_id_e               r_last;
    req_id_e               r_rsp_id;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_fault;

    logic                  w_idle;
    logic                  w_grant_core;
    logic                  w_grant_dbg;
    logic                  w_grant;
    logic [31:0]           w_addr;
    logic                  w_write;
    logic [2:0]            w_funct3;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [3:0]            w_we;
    logic [31:0]           w_wdata_rep;
    logic [31:0]           w_ldata;
    logic                  w_misalign;
    logic                  w_range_err;
    logic                  w_fault;
    logic                  w_rsp_take;

    // On a tie the port that did not win last time gets the slot.
    assign w_idle       = (r_state == IDLE);
    assign w_grant_core = w_idle && core_req_valid && (!dbg_req_valid || (r_last == REQ_DBG));
    assign w_grant_dbg  = w_idle && dbg_req_valid && !w_grant_core;
    assign w_grant      = w_grant_core || w_grant_dbg;

    assign w_addr   = w_grant_dbg ? dbg_req_addr   : core_req_addr;
    assign w_write  = w_grant_dbg ? dbg_req_write  : core_req_write;
    assign w_funct3 = w_grant_dbg ? dbg_req_funct3 : core_req_funct3;
    assign w_wdata  = w_grant_dbg ? dbg_req_wdata  : core_req_wdata;

    lsu_align u_align (
        .i_funct3   (w_funct3),
        .i_write    (w_write),
        .i_offset   (w_addr[1:0]),
        .i_wdata    (w_wdata),
        .i_rdata    (mem_rdata),
        .o_we       (w_we),
        .o_wdata    (w_wdata_rep),
        .o_ldata    (w_ldata),
        .o_misalign (w_misalign)
    );

    assign w_range_err = |w_addr[31:ADDR_WIDTH+2];
    assign w_fault     = w_misalign || w_range_err || !f3_legal(w_funct3, w_write);

    assign core_req_ready = w_grant_core;
    assign dbg_req_ready  = w_grant_dbg;

    assign mem_addr  = w_addr[ADDR_WIDTH+1:2];
    assign mem_wdata = w_wdata_rep;
    assign mem_we    = (w_grant && !w_fault) ? w_we : 4'b0000;

    assign w_rsp_take = (r_rsp_id == REQ_CORE) ? core_rsp_ready : dbg_rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= INIT;
            r_last      <= REQ_DBG;
            r_rsp_id    <= REQ_CORE;
            r_rsp_rdata <= '0;
            r_rsp_fault <= 1'b0;
        end else begin
            case (r_state)
                INIT: r_state <= IDLE;
                IDLE: begin
                    if (w_grant) begin
                        r_state     <= RESP;
                        r_last      <= w_grant_dbg ? REQ_DBG : REQ_CORE;
                        r_rsp_id    <= w_grant_dbg ? REQ_DBG : REQ_CORE;
                        r_rsp_rdata <= (w_fault || w_write) ? '0 : w_ldata;
                        r_rsp_fault <= w_fault;
                    end
                end
                RESP: begin
                    if (w_rsp_take) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= INIT;
            endcase
        end
    end

    assign core_rsp_valid = (r_state == RESP) && (r_rsp_id == REQ_CORE);
    assign dbg_rsp_valid  = (r_state == RESP) && (r_rsp_id == REQ_DBG);
    assign core_rsp_rdata = core_rsp_valid ? r_rsp_rdata : '0;
    assign dbg_rsp_rdata  = dbg_rsp_valid  ? r_rsp_rdata : '0;
    assign core_rsp_fault = core_rsp_valid && r_rsp_fault;
    assign dbg_rsp_fault  = dbg_rsp_valid  && r_rsp_fault;

endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// tb/tb_lsu_mem_arbiter.sv - self-checking bench for lsu_mem_arbiter against a behavioural memory model
module tb_lsu_mem_arbiter;

    localparam int AW = 10;

    logic        clk;
    logic        rst_n;
    logic        core_req_valid, core_req_ready, core_req_write;
    logic [31:0] core_req_addr, core_req_wdata, core_rsp_rdata;
    logic [2:0]  core_req_funct3;
    logic        core_rsp_valid, core_rsp_ready, core_rsp_fault;
    logic        dbg_req_valid, dbg_req_ready, dbg_req_write;
    logic [31:0] dbg_req_addr, dbg_req_wdata, dbg_rsp_rdata;
    logic [2:0]  dbg_req_funct3;
    logic        dbg_rsp_valid, dbg_rsp_ready, dbg_rsp_fault;
    logic [AW-1:0] mem_addr;
    logic [3:0]  mem_we;
    logic [31:0] mem_wdata, mem_rdata;

    logic [31:0] mem [0:(1<<AW)-1];
    logic [31:0] ref_mem [0:(1<<AW)-1];
    logic        mem_clr;
    int          m_last;
    int          n_checks;
    int          n_errors;

    lsu_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
        .core_req_addr(core_req_addr), .core_req_write(core_req_write),
        .core_req_funct3(core_req_funct3), .core_req_wdata(core_req_wdata),
        .core_rsp_valid(core_rsp_valid), .core_rsp_ready(core_rsp_ready),
        .core_rsp_rdata(core_rsp_rdata), .core_rsp_fault(core_rsp_fault),
        .dbg_req_valid(dbg_req_valid), .dbg_req_ready(dbg_req_ready),
        .dbg_req_addr(dbg_req_addr), .dbg_req_write(dbg_req_write),
        .dbg_req_funct3(dbg_req_funct3), .dbg_req_wdata(dbg_req_wdata),
        .dbg_rsp_valid(dbg_rsp_valid), .dbg_rsp_ready(dbg_rsp_ready),
        .dbg_rsp_rdata(dbg_rsp_rdata), .dbg_rsp_fault(dbg_rsp_fault),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < (1 << AW); i++) mem[i] <= 32'h0;
        end else begin
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: memory as an array of bytes-in-words, accesses judged by size and alignment.
    function automatic void model_acc(input logic [31:0] a, input logic w, input logic [2:0] f3,
                                      input logic [31:0] wd, output logic [31:0] rd,
                                      output logic flt, output logic [3:0] we);
        int size, off, idx;
        logic [31:0] v;
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        off  = a % 4;
        flt  = 1'b0;
        rd   = 32'h0;
        we   = 4'h0;
        if (a >= (32'd1 << (AW + 2))) flt = 1'b1;
        if (w && f3 > 3'd2) flt = 1'b1;
        if (!w && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) flt = 1'b1;
        if ((a % size) != 0) flt = 1'b1;
        if (!flt) begin
            idx = a / 4;
            if (w) begin
                for (int i = 0; i < size; i++) begin
                    ref_mem[idx][8*(off+i) +: 8] = wd[8*i +: 8];
                    we[off+i] = 1'b1;
                end
            end else begin
                v = ref_mem[idx] >> (8 * off);
                if (size < 4) begin
                    v = v & ((32'd1 << (8 * size)) - 1);
                    if (f3 < 3'd4 && v[8*size-1]) v = v | ~((32'd1 << (8 * size)) - 1);
                end
                rd = v;
            end
        end
    endfunction

    task automatic drive_req(input int p, input logic v, input logic [31:0] a, input logic w,
                             input logic [2:0] f3, input logic [31:0] wd);
        if (p == 0) begin
            core_req_valid = v; core_req_addr = a; core_req_write = w;
            core_req_funct3 = f3; core_req_wdata = wd;
        end else begin
            dbg_req_valid = v; dbg_req_addr = a; dbg_req_write = w;
            dbg_req_funct3 = f3; dbg_req_wdata = wd;
        end
    endtask

    task automatic do_acc(input int p, input logic [31:0] a, input logic w, input logic [2:0] f3,
                          input logic [31:0] wd, output logic [31:0] rd, output logic flt,
                          output logic [3:0] g_we, output logic [AW-1:0] g_addr, output logic [31:0] g_wdata);
        logic got;
        logic [31:0] erd;
        logic eflt;
        logic [3:0] ewe;
        got = 1'b0;
        @(posedge clk); #1 drive_req(p, 1'b1, a, w, f3, wd);
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = (p == 0) ? core_req_ready : dbg_req_ready;
        end
        check_eq("acc_grant", {31'h0, got}, 32'h1);
        g_we = mem_we; g_addr = mem_addr; g_wdata = mem_wdata;
        model_acc(a, w, f3, wd, erd, eflt, ewe);
        m_last = p;
        @(posedge clk); #1 drive_req(p, 1'b0, a, w, f3, wd);
        @(negedge clk);
        check_eq("acc_rsp_valid", {31'h0, (p == 0) ? core_rsp_valid : dbg_rsp_valid}, 32'h1);
        rd  = (p == 0) ? core_rsp_rdata : dbg_rsp_rdata;
        flt = (p == 0) ? core_rsp_fault : dbg_rsp_fault;
    endtask

    logic [31:0]   t_rd, t_wd, e_rd;
    logic          t_flt, e_flt;
    logic [3:0]    t_we, e_we;
    logic [AW-1:0] t_addr;
    logic [3:0]    t_exp;
    logic          t_got;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        clk = 0; rst_n = 0; mem_clr = 1; m_last = 1;
        n_checks = 0; n_errors = 0;
        for (int i = 0; i < (1 << AW); i++) ref_mem[i] = 32'h0;
        core_rsp_ready = 1; dbg_rsp_ready = 1;
        drive_req(0, 1'b1, 32'h0, 1'b0, 3'd2, 32'h0);
        drive_req(1, 1'b1, 32'h4, 1'b0, 3'd2, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_core_ready", {31'h0, core_req_ready}, 0);
        check_eq("rst_dbg_ready", {31'h0, dbg_req_ready}, 0);
        check_eq("rst_rsp_valid", {30'h0, core_rsp_valid, dbg_rsp_valid}, 0);
        check_eq("rst_rdata", core_rsp_rdata | dbg_rsp_rdata, 0);
        check_eq("rst_fault", {30'h0, core_rsp_fault, dbg_rsp_fault}, 0);
        check_eq("rst_mem_we", {28'h0, mem_we}, 0);
        mem_clr = 0;

        // Both ports valid from reset: one INIT cycle, then core, dbg, core, dbg.
        @(posedge clk); #1 rst_n = 1;
        for (int c = 0; c <= 8; c++) begin
            @(negedge clk);
            case (c % 4)
                1: t_exp = 4'b1000;
                2: t_exp = 4'b0010;
                3: t_exp = 4'b0100;
                default: t_exp = (c == 0) ? 4'b0000 : 4'b0001;
            endcase
            check_eq("arb_seq", {28'h0, core_req_ready, dbg_req_ready, core_rsp_valid, dbg_rsp_valid},
                     {28'h0, t_exp});
        end
        drive_req(0, 1'b0, 32'h0, 1'b0, 3'd2, 32'h0);
        drive_req(1, 1'b0, 32'h4, 1'b0, 3'd2, 32'h0);
        m_last = 1;

        do_acc(1, 32'h0, 1'b1, 3'd2, 32'hDEADBEEF, t_rd, t_flt, t_we, t_addr, t_wd);
        do_acc(1, 32'h4, 1'b1, 3'd2, 32'h00000005, t_rd, t_flt, t_we, t_addr, t_wd);

        do_acc(0, 32'h3, 1'b0, 3'd0, 32'h0, t_rd, t_flt, t_we, t_addr, t_wd);
        check_eq("lb3_rdata", t_rd, 32'hFFFFFFDE);
        check_eq("lb3_fault", {31'h0, t_flt}, 0);
        do_acc(0, 32'h3, 1'b0, 3'd4, 32'h0, t_rd, t_flt, t_we, t_addr, t_wd);
        check_eq("lbu3_rdata", t_rd, 32'h000000DE);
        do_acc(0, 32'h2, 1'b0, 3'd1, 32'h0, t_rd, t_flt, t_we, t_addr, t_wd);
        check_eq("lh2_rdata", t_rd, 32'hFFFFDEAD);
        do_acc(0, 32'h0, 1'b0, 3'd5, 32'h0, t_rd, t_flt, t_we, t_addr, t_wd);
        check_eq("lhu0_rdata", t_rd, 32'h0000BEEF);

        do_acc(0, 32'h6, 1'b1, 3'd1, 32'h1234ABCD, t_rd, t_flt, t_we, t_addr, t_wd);
        check_eq("sh6_we", {28'h0, t_we}, 32'hC);
        check_eq("sh6_addr", {22'h0, t_addr}, 32'h1);
        check_eq("sh6_wdata", t_wd, 32'hABCDABCD);
        do_acc(0, 32'h4, 1'b0, 3'd2, 32'h0, t_rd, t_flt, t_we, t_addr, t_wd);
        check_eq("lw4_rdata", t_rd, 32'hABCD0005);

        do_acc(0, 32'h2, 1'b1, 3'd2, 32'h11111111, t_rd, t_flt, t_we, t_addr, t_wd);
        check_eq("sw2_fault", {31'h0, t_flt}, 1);
        check_eq("sw2_we", {28'h0, t_we}, 0);
        do_acc(0, 32'h0, 1'b0, 3'd2, 32'h0, t_rd, t_flt, t_we, t_addr, t_wd);
        check_eq("sw2_mem_kept", t_rd, 32'hDEADBEEF);
        do_acc(0, 32'h1000, 1'b0, 3'd2, 32'h0, t_rd, t_flt, t_we, t_addr, t_wd);
        check_eq("oor_fault", {31'h0, t_flt}, 1);
        check_eq("oor_rdata", t_rd, 0);
        do_acc(0, 32'h0, 1'b0, 3'd3, 32'h0, t_rd, t_flt, t_we, t_addr, t_wd);
        check_eq("f3_3_fault", {31'h0, t_flt}, 1);

        // Backpressure on the core response while debug waits with a store.
        @(posedge clk); #1 core_rsp_ready = 0; drive_req(0, 1'b1, 32'h0, 1'b0, 3'd2, 32'h0);
        t_got = 0;
        for (int i = 0; i < 20 && !t_got; i++) begin @(negedge clk); t_got = core_req_ready; end
        check_eq("bp_grant", {31'h0, t_got}, 1);
        model_acc(32'h0, 1'b0, 3'd2, 32'h0, e_rd, e_flt, e_we);
        m_last = 0;
        @(posedge clk); #1 drive_req(0, 1'b0, 32'h0, 1'b0, 3'd2, 32'h0);
        drive_req(1, 1'b1, 32'h8, 1'b1, 3'd2, 32'h00000055);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_eq("bp_rsp_valid", {31'h0, core_rsp_valid}, 1);
            check_eq("bp_rdata", core_rsp_rdata, e_rd);
            check_eq("bp_dbg_ready", {31'h0, dbg_req_ready}, 0);
            check_eq("bp_mem_we", {28'h0, mem_we}, 0);
        end
        core_rsp_ready = 1;
        @(negedge clk);
        check_eq("bp_dbg_grant", {31'h0, dbg_req_ready}, 1);
        check_eq("bp_dbg_we", {28'h0, mem_we}, 32'hF);
        model_acc(32'h8, 1'b1, 3'd2, 32'h00000055, e_rd, e_flt, e_we);
        m_last = 1;
        @(posedge clk); #1 drive_req(1, 1'b0, 32'h8, 1'b1, 3'd2, 32'h55);
        @(negedge clk);
        check_eq("bp_dbg_rsp", {31'h0, dbg_rsp_valid}, 1);

        // Reset while a response is held, with a new core request pending.
        @(posedge clk); #1 core_rsp_ready = 0; drive_req(0, 1'b1, 32'h4, 1'b0, 3'd2, 32'h0);
        t_got = 0;
        for (int i = 0; i < 20 && !t_got; i++) begin @(negedge clk); t_got = core_req_ready; end
        check_eq("rm_grant", {31'h0, t_got}, 1);
        @(posedge clk); #1 drive_req(0, 1'b1, 32'h0, 1'b0, 3'd2, 32'h0);
        @(negedge clk);
        check_eq("rm_rsp_before", {31'h0, core_rsp_valid}, 1);
        #2 rst_n = 0;
        #1;
        check_eq("rm_rsp_dropped", {31'h0, core_rsp_valid}, 0);
        check_eq("rm_rdata_zero", core_rsp_rdata, 0);
        check_eq("rm_ready_zero", {31'h0, core_req_ready}, 0);
        check_eq("rm_we_zero", {28'h0, mem_we}, 0);
        @(posedge clk); #1 rst_n = 1; core_rsp_ready = 1; m_last = 1;
        @(negedge clk);
        check_eq("rm_init_ready", {31'h0, core_req_ready}, 0);
        @(negedge clk);
        check_eq("rm_pending_grant", {31'h0, core_req_ready}, 1);
        model_acc(32'h0, 1'b0, 3'd2, 32'h0, e_rd, e_flt, e_we);
        m_last = 0;
        @(posedge clk); #1 drive_req(0, 1'b0, 32'h0, 1'b0, 3'd2, 32'h0);
        @(negedge clk);
        check_eq("rm_rsp_valid", {31'h0, core_rsp_valid}, 1);
        check_eq("rm_rdata", core_rsp_rdata, e_rd);

        // Random traffic on one or both ports against the reference model.
        for (int it = 0; it < 200; it++) begin
            logic [31:0] ra [2];
            logic [31:0] rwd [2];
            logic        rw [2];
            logic [2:0]  rf [2];
            int mask, pend, gp, ep;
            mask = $urandom_range(1, 3);
            for (int p = 0; p < 2; p++) begin
                ra[p] = $urandom_range(0, 63);
                if ($urandom_range(0, 7) == 0) ra[p] = ra[p] | (32'h1 << $urandom_range(12, 31));
                rw[p]  = 1'($urandom_range(0, 1));
                rf[p]  = 3'($urandom_range(0, 7));
                rwd[p] = $urandom;
            end
            @(posedge clk); #1;
            for (int p = 0; p < 2; p++)
                if (mask[p]) drive_req(p, 1'b1, ra[p], rw[p], rf[p], rwd[p]);
            pend = mask;
            while (pend != 0) begin
                gp = -1;
                for (int i = 0; i < 20 && gp < 0; i++) begin
                    @(negedge clk);
                    if (core_req_ready) gp = 0;
                    else if (dbg_req_ready) gp = 1;
                end
                ep = (pend == 3) ? ((m_last == 1) ? 0 : 1) : ((pend == 1) ? 0 : 1);
                check_eq("rand_grant", gp, ep);
                if (gp < 0) begin
                    pend = 0;
                end else begin
                    check_eq("rand_one_ready", {31'h0, core_req_ready & dbg_req_ready}, 0);
                    model_acc(ra[gp], rw[gp], rf[gp], rwd[gp], e_rd, e_flt, e_we);
                    m_last = gp;
                    check_eq("rand_we", {28'h0, mem_we}, {28'h0, e_we});
                    if (e_we != 0) check_eq("rand_maddr", {22'h0, mem_addr}, ra[gp] >> 2);
                    @(posedge clk); #1 drive_req(gp, 1'b0, ra[gp], rw[gp], rf[gp], rwd[gp]);
                    pend = pend & ~(1 << gp);
                    @(negedge clk);
                    check_eq("rand_rsp_valid", {30'h0, core_rsp_valid, dbg_rsp_valid},
                             (gp == 0) ? 32'h2 : 32'h1);
                    check_eq("rand_rdata", (gp == 0) ? core_rsp_rdata : dbg_rsp_rdata, e_rd);
                    check_eq("rand_fault", {31'h0, (gp == 0) ? core_rsp_fault : dbg_rsp_fault},
                             {31'h0, e_flt});
                    if (pend != 0)
                        check_eq("rand_wait_ready", {30'h0, core_req_ready, dbg_req_ready}, 0);
                end
            end
        end

        for (int i = 0; i < 16; i++) check_eq("final_mem", mem[i], ref_mem[i]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
